// File: rtl/rat_int_debounce.sv
// Interrupt button conditioner for the RAT MCU: synchronizer, press/release
// debounce and a fixed-width one-shot on INT_OUT, plus a wrapping press counter.
module rat_int_debounce #(
   parameter int unsigned STABLE_CNT  = 2,
   parameter int unsigned PULSE_WIDTH = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       BTN_INT,
   output logic       INT_OUT,
   output logic       BTN_CLEAN,
   output logic [7:0] PRESS_COUNT
);

   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CNT);
   localparam logic [7:0] PULSE_LIM  = 8'(PULSE_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      PULSE,
      HELD,
      DB_RELEASE
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       sync1;
   logic       btn_s;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   logic [7:0] cnt_inc;
   logic       int_nxt;
   logic       clean_nxt;
   logic [7:0] count_nxt;

   // Two-flop synchronizer for the asynchronous button level.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1 <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sync1 <= BTN_INT;
         btn_s <= sync1;
      end
   end

   assign cnt_inc = cnt + 8'd1;

   // Next-state and next-output logic; outputs hold unless a transition changes them.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      int_nxt   = INT_OUT;
      clean_nxt = BTN_CLEAN;
      count_nxt = PRESS_COUNT;
      case (state)
         IDLE: begin
            if (btn_s) begin
               if (STABLE_LIM == 8'd1) begin
                  state_nxt = PULSE;
                  cnt_nxt   = '0;
                  int_nxt   = 1'b1;
                  clean_nxt = 1'b1;
                  count_nxt = PRESS_COUNT + 8'd1;
               end else begin
                  state_nxt = DB_PRESS;
                  cnt_nxt   = 8'd1;
               end
            end
         end
         DB_PRESS: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt_inc == STABLE_LIM) begin
               state_nxt = PULSE;
               cnt_nxt   = '0;
               int_nxt   = 1'b1;
               clean_nxt = 1'b1;
               count_nxt = PRESS_COUNT + 8'd1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         PULSE: begin
            // Button is ignored here so a release cannot shorten the pulse.
            if (cnt_inc == PULSE_LIM) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
               int_nxt   = 1'b0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         HELD: begin
            if (!btn_s) begin
               if (STABLE_LIM == 8'd1) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  clean_nxt = 1'b0;
               end else begin
                  state_nxt = DB_RELEASE;
                  cnt_nxt   = 8'd1;
               end
            end
         end
         DB_RELEASE: begin
            if (btn_s) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
            end else if (cnt_inc == STABLE_LIM) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               clean_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, sample counter and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         cnt         <= '0;
         INT_OUT     <= 1'b0;
         BTN_CLEAN   <= 1'b0;
         PRESS_COUNT <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         INT_OUT     <= int_nxt;
         BTN_CLEAN   <= clean_nxt;
         PRESS_COUNT <= count_nxt;
      end
   end

endmodule

// File: tb/tb_rat_int_debounce.sv
// Self-checking bench for rat_int_debounce: directed scenarios plus random
// bouncy stimulus compared against a run-length behavioural model.
module tb_rat_int_debounce;

   localparam int unsigned STABLE_CNT  = 2;
   localparam int unsigned PULSE_WIDTH = 2;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       BTN_INT;
   logic       INT_OUT;
   logic       BTN_CLEAN;
   logic [7:0] PRESS_COUNT;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   rat_int_debounce #(
      .STABLE_CNT (STABLE_CNT),
      .PULSE_WIDTH(PULSE_WIDTH)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN_INT    (BTN_INT),
      .INT_OUT    (INT_OUT),
      .BTN_CLEAN  (BTN_CLEAN),
      .PRESS_COUNT(PRESS_COUNT)
   );

   // Reference model: debounced level changes after STABLE_CNT consecutive
   // differing samples; a rising change launches a PULSE_WIDTH pulse during
   // which the input is not looked at.
   bit m_s1, m_s2, m_b, m_clean, m_int;
   int m_streak, m_left, m_count;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_s1 = 0; m_s2 = 0; m_clean = 0; m_int = 0;
         m_streak = 0; m_left = 0; m_count = 0;
      end else begin
         m_b  = m_s2;
         m_s2 = m_s1;
         m_s1 = BTN_INT;
         if (m_left > 0) begin
            m_left--;
            m_streak = 0;
         end else if (m_b != m_clean) begin
            m_streak++;
            if (m_streak == STABLE_CNT) begin
               m_clean  = m_b;
               m_streak = 0;
               if (m_b) begin
                  m_left  = PULSE_WIDTH;
                  m_count = (m_count + 1) % 256;
               end
            end
         end else begin
            m_streak = 0;
         end
         m_int = (m_left > 0);
      end
   end

   // Observation of INT_OUT pulses seen at the falling edge.
   int obs_pulses, obs_maxrun, obs_mingap, cur_run, cur_gap;
   bit prev_int;

   task automatic clear_stats();
      obs_pulses = 0; obs_maxrun = 0; obs_mingap = 1000000;
      cur_run = 0; cur_gap = 0; prev_int = INT_OUT;
   endtask

   task automatic step(input logic v);
      @(negedge CLK);
      if (INT_OUT && !prev_int) begin
         if (obs_pulses > 0 && cur_gap < obs_mingap) obs_mingap = cur_gap;
         obs_pulses++;
         cur_run = 0;
      end
      if (INT_OUT) begin
         cur_run++;
         if (cur_run > obs_maxrun) obs_maxrun = cur_run;
      end
      if (!INT_OUT && prev_int) cur_gap = 0;
      if (!INT_OUT) cur_gap++;
      prev_int = INT_OUT;
      BTN_INT  = v;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0; BTN_INT = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; BTN_INT = 1'b0;
      repeat (2) @(negedge CLK);
      BTN_INT = 1'b1;
      repeat (3) @(negedge CLK);
      total++; if (INT_OUT !== 1'b0) begin bad++; $display("FAIL reset_int got=%b exp=0", INT_OUT); end
      total++; if (BTN_CLEAN !== 1'b0) begin bad++; $display("FAIL reset_clean got=%b exp=0", BTN_CLEAN); end
      total++; if (PRESS_COUNT !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", PRESS_COUNT); end
      BTN_INT = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_glitch();
      clear_stats();
      step(1'b1);
      for (int j = 0; j < 15; j++) begin
         step(1'b0);
         total++; if (INT_OUT !== m_int) begin bad++; $display("FAIL glitch_int cyc=%0d got=%b exp=%b", j, INT_OUT, m_int); end
      end
      total++; if (obs_pulses != 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", obs_pulses); end
      total++; if (BTN_CLEAN !== 1'b0) begin bad++; $display("FAIL glitch_clean got=%b exp=0", BTN_CLEAN); end
      total++; if (PRESS_COUNT !== 8'd0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", PRESS_COUNT); end
   endtask

   task automatic test_short_press();
      int rise = -1;
      clear_stats();
      for (int j = 0; j < 20; j++) begin
         step(j < 3);
         if (j >= 1 && INT_OUT === 1'b1 && rise < 0) rise = j - 1;
      end
      total++; if (rise != int'(STABLE_CNT) + 1) begin bad++; $display("FAIL short_latency got=%0d exp=%0d", rise, STABLE_CNT + 1); end
      total++; if (obs_pulses != 1) begin bad++; $display("FAIL short_pulses got=%0d exp=1", obs_pulses); end
      total++; if (obs_maxrun != int'(PULSE_WIDTH)) begin bad++; $display("FAIL short_width got=%0d exp=%0d", obs_maxrun, PULSE_WIDTH); end
      total++; if (PRESS_COUNT !== 8'd1) begin bad++; $display("FAIL short_count got=%0d exp=1", PRESS_COUNT); end
      total++; if (BTN_CLEAN !== 1'b0) begin bad++; $display("FAIL short_clean got=%b exp=0", BTN_CLEAN); end
   endtask

   task automatic test_long_hold();
      int fall = -1;
      int start = m_count;
      clear_stats();
      for (int j = 0; j < 1000; j++) step(1'b1);
      total++; if (BTN_CLEAN !== 1'b1) begin bad++; $display("FAIL hold_clean got=%b exp=1", BTN_CLEAN); end
      for (int j = 0; j < 15; j++) begin
         step(1'b0);
         if (j >= 1 && BTN_CLEAN === 1'b0 && fall < 0) fall = j - 1;
      end
      total++; if (fall != int'(STABLE_CNT) + 1) begin bad++; $display("FAIL hold_release_lat got=%0d exp=%0d", fall, STABLE_CNT + 1); end
      total++; if (obs_pulses != 1) begin bad++; $display("FAIL hold_pulses got=%0d exp=1", obs_pulses); end
      total++; if (obs_maxrun != int'(PULSE_WIDTH)) begin bad++; $display("FAIL hold_width got=%0d exp=%0d", obs_maxrun, PULSE_WIDTH); end
      total++; if (PRESS_COUNT !== 8'((start + 1) % 256)) begin bad++; $display("FAIL hold_count got=%0d exp=%0d", PRESS_COUNT, (start + 1) % 256); end
   endtask

   task automatic test_release_bounce();
      int start = m_count;
      clear_stats();
      repeat (10) step(1'b1);
      for (int j = 0; j < 10; j++) step((j % 2) == 1);
      repeat (20) step(1'b0);
      total++; if (obs_pulses != 1) begin bad++; $display("FAIL bounce_pulses got=%0d exp=1", obs_pulses); end
      total++; if (PRESS_COUNT !== 8'((start + 1) % 256)) begin bad++; $display("FAIL bounce_count got=%0d exp=%0d", PRESS_COUNT, (start + 1) % 256); end
      total++; if (BTN_CLEAN !== 1'b0) begin bad++; $display("FAIL bounce_clean got=%b exp=0", BTN_CLEAN); end
   endtask

   task automatic test_random();
      clear_stats();
      for (int s = 0; s < 400; s++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(1, 0));
         len = $urandom_range(8, 1);
         for (int k = 0; k < len; k++) begin
            step(lvl);
            total++; if (INT_OUT !== m_int) begin bad++; $display("FAIL rand_int seg=%0d got=%b exp=%b", s, INT_OUT, m_int); end
            total++; if (BTN_CLEAN !== m_clean) begin bad++; $display("FAIL rand_clean seg=%0d got=%b exp=%b", s, BTN_CLEAN, m_clean); end
            total++; if (PRESS_COUNT !== 8'(m_count)) begin bad++; $display("FAIL rand_count seg=%0d got=%0d exp=%0d", s, PRESS_COUNT, m_count); end
         end
      end
      repeat (12) step(1'b0);
      total++; if (obs_maxrun > int'(PULSE_WIDTH)) begin bad++; $display("FAIL rand_maxwidth got=%0d exp<=%0d", obs_maxrun, PULSE_WIDTH); end
   endtask

   task automatic test_wrap();
      do_reset();
      clear_stats();
      repeat (256) begin
         repeat (3) step(1'b1);
         repeat (10) step(1'b0);
      end
      repeat (10) step(1'b0);
      total++; if (obs_pulses != 256) begin bad++; $display("FAIL wrap_pulses got=%0d exp=256", obs_pulses); end
      total++; if (PRESS_COUNT !== 8'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", PRESS_COUNT); end
      total++; if (obs_maxrun != int'(PULSE_WIDTH)) begin bad++; $display("FAIL wrap_width got=%0d exp=%0d", obs_maxrun, PULSE_WIDTH); end
      total++; if (obs_mingap < int'(2 * STABLE_CNT + 1)) begin bad++; $display("FAIL wrap_gap got=%0d exp>=%0d", obs_mingap, 2 * STABLE_CNT + 1); end
   endtask

   task automatic test_reset_mid_pulse();
      bit found = 0;
      int rise  = -1;
      clear_stats();
      for (int j = 0; j < 20; j++) begin
         step(1'b1);
         if (INT_OUT === 1'b1) begin found = 1; break; end
      end
      total++; if (!found) begin bad++; $display("FAIL midrst_nopulse got=0 exp=1"); end
      RST_N = 1'b0;
      #1;
      total++; if (INT_OUT !== 1'b0) begin bad++; $display("FAIL midrst_int got=%b exp=0", INT_OUT); end
      total++; if (PRESS_COUNT !== 8'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", PRESS_COUNT); end
      total++; if (BTN_CLEAN !== 1'b0) begin bad++; $display("FAIL midrst_clean got=%b exp=0", BTN_CLEAN); end
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         if (INT_OUT === 1'b1 && rise < 0) rise = i;
      end
      total++; if (rise != int'(STABLE_CNT) + 1) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", rise, STABLE_CNT + 1); end
      total++; if (PRESS_COUNT !== 8'd1) begin bad++; $display("FAIL midrst_newcount got=%0d exp=1", PRESS_COUNT); end
      repeat (10) step(1'b0);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_short_press();
      test_long_hold();
      test_release_bounce();
      test_random();
      test_wrap();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
